// File: rtl/dmem_responder.sv
// Data-memory slave: word RAM with byte lanes, MMIO TX FIFO, STATUS and CYCLES.
// Combinational reads; CYCLES register present only when DMEM_CYCLE_COUNTER_EN is defined.
`timescale 1ns/1ps
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   ram_q [DEPTH_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          tx_valid_q, tx_valid_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic [3:0]    count_sat;
   logic [31:0]   rd_data;

   logic [AW-1:0] widx;
   logic [7:0]    off;
   logic          is_mmio, full, empty, pop, push, wr_txdata, wr_status_clr;
   logic          unused_addr;

   assign widx        = daddr[AW+1:2];
   assign off         = daddr[7:0];
   assign is_mmio     = (daddr[31] == MMIO_BASE[31]);
   assign unused_addr = ^{daddr[30:8], daddr[1:0]};

   assign full          = (count_q == CW'(FIFO_DEPTH));
   assign empty         = (count_q == '0);
   assign pop           = tx_valid_q && tx_ready;
   assign wr_txdata     = !reset && is_mmio && (off == 8'h00) && dwe[0];
   assign wr_status_clr = is_mmio && (off == 8'h04) && dwe[0] && dwdata[2];
   // A push into a full FIFO is only accepted when the head leaves this same edge.
   assign push          = wr_txdata && (!full || pop);

`ifdef DMEM_CYCLE_COUNTER_EN
   logic [31:0] cycles_q, cycles_d;
   logic        wr_cycles;

   assign wr_cycles = is_mmio && (off == 8'h08) && (dwe != 4'b0000);

   always_comb begin
      cycles_d = wr_cycles ? 32'h0 : cycles_q + 32'h1;
   end

   always_ff @(posedge clk) begin
      if (reset) cycles_q <= 32'h0;
      else       cycles_q <= cycles_d;
   end
`endif

   always_comb begin
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      count_d    = count_q + CW'(push) - CW'(pop);
      ovf_d      = ovf_q;
      if (wr_status_clr) ovf_d = 1'b0;
      if (wr_txdata && full && !pop) ovf_d = 1'b1;
      tx_valid_d = (count_d != '0);
      tx_data_d  = tx_data_q;
      // Next head is the incoming byte only when nothing older survives this edge.
      if (count_d != '0)
         tx_data_d = (count_q == CW'(pop)) ? dwdata[7:0] : fifo_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= dwdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset && !is_mmio) begin
         for (int i = 0; i < 4; i++)
            if (dwe[i]) ram_q[widx][8*i +: 8] <= dwdata[8*i +: 8];
      end
   end

   always_comb begin
      count_sat = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
   end

   always_comb begin
      rd_data = 32'h0;
      if (!is_mmio) begin
         rd_data = ram_q[widx];
      end else begin
         case (off)
            8'h04:   rd_data = {24'h0, count_sat, 1'b0, ovf_q, empty, full};
`ifdef DMEM_CYCLE_COUNTER_EN
            8'h08:   rd_data = cycles_q;
`endif
            default: rd_data = 32'h0;
         endcase
      end
   end

   assign drdata   = rd_data;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized check of dmem_responder against a queue/array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;
   localparam int DW = 1024;
   localparam int FD = 8;
   localparam logic [31:0] MB = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] daddr, dwdata;
   logic [3:0]  dwe;
   logic        tx_ready;
   logic [31:0] drdata;
   logic [7:0]  tx_data;
   logic        tx_valid;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit [31:0]   m_ram [int];
   int          m_keys [$];
   byte unsigned m_q [$];
   bit          m_ovf;
   bit [31:0]   m_cyc;

   dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .MMIO_BASE(MB)) dut (
      .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
      .drdata(drdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic int ram_key(input logic [31:0] a);
      return int'((a >> 2) % 32'(DW));
   endfunction

   function automatic logic [31:0] m_status();
      int c;
      c = m_q.size();
      if (c > 15) c = 15;
      return {24'h0, c[3:0], 1'b0, m_ovf, (m_q.size() == 0), (m_q.size() == FD)};
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (!a[31]) return m_ram.exists(ram_key(a)) ? m_ram[ram_key(a)] : 32'h0;
      case (a[7:0])
         8'h04: return m_status();
`ifdef DMEM_CYCLE_COUNTER_EN
         8'h08: return m_cyc;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic rdy);
      daddr = a; dwdata = wd; dwe = we; tx_ready = rdy;
      #1;
   endtask

   // Apply the model for the current inputs, then advance past the edge.
   task automatic tick();
      bit pop, full, push;
      int k;
      bit [31:0] w;
      push = 0;
      if (reset) begin
         m_q.delete(); m_ovf = 0; m_cyc = 0;
      end else begin
         pop  = (m_q.size() != 0) && tx_ready;
         full = (m_q.size() == FD);
         m_cyc++;
         if (!daddr[31]) begin
            if (dwe != 4'b0000) begin
               k = ram_key(daddr);
               w = m_ram.exists(k) ? m_ram[k] : 32'h0;
               if (!m_ram.exists(k)) m_keys.push_back(k);
               for (int i = 0; i < 4; i++) if (dwe[i]) w[8*i +: 8] = dwdata[8*i +: 8];
               m_ram[k] = w;
            end
         end else begin
            case (daddr[7:0])
               8'h00: if (dwe[0]) begin
                  if (!full || pop) push = 1; else m_ovf = 1;
               end
               8'h04: if (dwe[0] && dwdata[2]) m_ovf = 0;
               8'h08: if (dwe != 4'b0000) m_cyc = 0;
               default: ;
            endcase
         end
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(dwdata[7:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_tx(input string tag);
      chk({tag, "_vld"}, {31'h0, tx_valid}, {31'h0, (m_q.size() != 0)});
      if (m_q.size() != 0) chk({tag, "_dat"}, {24'h0, tx_data}, {24'h0, m_q[0]});
   endtask

   initial begin
      bit ram_new;
      int r, k;
      logic [31:0] a;
      reset = 1'b1;
      drive(32'h0, 32'h0, 4'h0, 1'b0);
      tick(); tick();
      drive(MB, 32'h77, 4'h1, 1'b0);
      tick();
      chk("rst_vld", {31'h0, tx_valid}, 32'h0);
      chk("rst_dat", {24'h0, tx_data}, 32'h0);
      drive(MB + 4, 0, 4'h0, 1'b0);
      chk("rst_status", drdata, 32'h2);
      drive(MB + 8, 0, 4'h0, 1'b0);
      chk("rst_cycles", drdata, 32'h0);
      reset = 1'b0;

      // byte lanes and same-cycle read of old data
      drive(32'h10, 32'hDEADBEEF, 4'hF, 1'b0); tick();
      drive(32'h10, 32'h0000_5500, 4'h2, 1'b0);
      chk("ram_old", drdata, 32'hDEADBEEF);
      tick();
      drive(32'h10, 0, 4'h0, 1'b0);
      chk("ram_lane", drdata, 32'hDEAD55EF);
      drive(32'h13, 0, 4'h0, 1'b0);
      chk("ram_lowbits", drdata, 32'hDEAD55EF);
      drive(32'h0, 32'h1234, 4'hF, 1'b0); tick();
      drive(32'h1000, 0, 4'h0, 1'b0);
      chk("ram_wrap", drdata, 32'h0000_1234);

      // overflow then drain
      for (int i = 1; i <= 9; i++) begin
         drive(MB, i, 4'h1, 1'b0); tick();
      end
      drive(MB + 4, 0, 4'h0, 1'b0);
      chk("ovf_status", drdata, 32'h85);
      drive(MB + 4, 0, 4'h0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         chk("drain_vld", {31'h0, tx_valid}, 32'h1);
         chk("drain_dat", {24'h0, tx_data}, i);
         tick();
      end
      chk("drained_vld", {31'h0, tx_valid}, 32'h0);
      chk("drained_status", drdata, 32'h06);
      drive(MB + 4, 32'h4, 4'h1, 1'b1); tick();
      drive(MB + 4, 0, 4'h0, 1'b1);
      chk("ovf_clear", drdata, 32'h02);

      // registered tx_valid latency
      drive(MB, 32'hA5, 4'h1, 1'b0);
      chk("push_pre_vld", {31'h0, tx_valid}, 32'h0);
      tick();
      drive(32'h10, 0, 4'h0, 1'b0);
      chk("push_vld", {31'h0, tx_valid}, 32'h1);
      chk("push_dat", {24'h0, tx_data}, 32'hA5);
      drive(32'h10, 0, 4'h0, 1'b1); tick();
      chk_tx("pop_one");

      // full + pop + push in one edge
      for (int i = 0; i < FD; i++) begin
         drive(MB, 32'h10 + i, 4'h1, 1'b0); tick();
      end
      drive(MB, 32'hEE, 4'h1, 1'b1); tick();
      drive(MB + 4, 0, 4'h0, 1'b0);
      chk("full_pushpop", drdata, 32'h81);
      chk("full_pushpop_model", drdata, m_status());
      drive(MB + 4, 0, 4'h0, 1'b1);
      for (int i = 0; i < 20 && m_q.size() != 0; i++) begin
         chk_tx("full_drain"); tick();
      end
      chk_tx("full_drained");

      // cycle counter
      drive(MB + 8, 32'h0, 4'hF, 1'b0); tick();
      drive(32'h10, 0, 4'h0, 1'b0);
      repeat (10) tick();
      drive(MB + 8, 0, 4'h0, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
      chk("cycles10", drdata, 32'd10);
`else
      chk("cycles10", drdata, 32'd0);
`endif
      chk("cycles_model", drdata, m_read(daddr));

      // reset mid-transfer
      for (int i = 0; i < 3; i++) begin
         drive(MB, 32'h30 + i, 4'h1, 1'b0); tick();
      end
      chk("pre_rst_vld", {31'h0, tx_valid}, 32'h1);
      reset = 1'b1; drive(32'h10, 0, 4'h0, 1'b1); tick();
      reset = 1'b0;
      chk("mid_rst_vld", {31'h0, tx_valid}, 32'h0);
      chk("mid_rst_dat", {24'h0, tx_data}, 32'h0);
      drive(MB + 4, 0, 4'h0, 1'b0);
      chk("mid_rst_status", drdata, 32'h2);
      drive(MB + 8, 0, 4'h0, 1'b0);
      chk("mid_rst_cycles", drdata, 32'h0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         ram_new = 0;
         reset = ($urandom_range(0, 79) == 0);
         case (r)
            0, 1, 2: begin
               a = (($urandom_range(0, 63) << 2) + 4096 * $urandom_range(0, 1000))
                   | $urandom_range(0, 3);
               ram_new = !m_ram.exists(ram_key(a));
               drive(a, $urandom, ram_new ? 4'hF : 4'($urandom), $urandom_range(0, 1));
            end
            3, 4: begin
               if (m_keys.size() != 0) begin
                  k = m_keys[$urandom_range(0, m_keys.size() - 1)];
                  a = ((k << 2) + 4096 * $urandom_range(0, 1000)) | $urandom_range(0, 3);
               end else a = MB + 4;
               drive(a, $urandom, 4'h0, $urandom_range(0, 1));
            end
            5, 6: drive(MB, $urandom, 4'($urandom) | 4'h1, $urandom_range(0, 3) == 0);
            7: drive(MB + 4, $urandom, 4'($urandom), $urandom_range(0, 1));
            8: drive(MB + 8, $urandom, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
                     $urandom_range(0, 1));
            default: drive(MB + 32'($urandom_range(0, 255)), $urandom, 4'($urandom),
                           $urandom_range(0, 1));
         endcase
         if (!ram_new) chk("rnd_rd", drdata, m_read(daddr));
         tick();
         chk_tx("rnd_tx");
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
